mii_tx_framer: RTL and testbench

Transmit-side MII framer, the return path of the MII-receive-to-UART bridge. It takes a byte stream (one frame per `s_last`-terminated burst, e.g. bytes arriving from the UART receiver) and emits a complete Ethernet frame on a 4-bit MII TX interface. The frame is preamble, SFD, the payload, zero padding up to the minimum frame length, a generated FCS, and an enforced inter-frame gap. It is clocked by the PHY's 25 MHz MII TX clock.

---
 rtl/mii_pkg.sv | 20 ++
 rtl/mii_tx_framer_if.sv | 12 +
 rtl/crc32_nibble.sv | 22 ++
 rtl/mii_tx_framer.sv | 182 ++++++++++++++++++
 tb/tb_mii_tx_framer.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mii_pkg.sv
// Shared MII definitions: nibble codes, CRC-32 constants and the TX state set.
package mii_pkg;

   localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
   localparam logic [3:0]  SFD_NIB      = 4'hD;
   localparam logic [31:0] CRC_POLY     = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_RESIDUE  = 32'hDEBB20E3;

   // State register encodes what is on the wire during the current cycle
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_DATA,
      ST_PAD,
      ST_FCS,
      ST_IFG
   } tx_state_e;

endpackage

// File: rtl/mii_tx_framer_if.sv
// Byte-stream handshake feeding the MII TX framer.
interface mii_tx_framer_if;

   logic [7:0] s_data;
   logic       s_valid;
   logic       s_last;
   logic       s_ready;

   modport master (output s_data, output s_valid, output s_last, input s_ready);
   modport slave  (input s_data, input s_valid, input s_last, output s_ready);

endinterface

// File: rtl/crc32_nibble.sv
// Combinational reflected CRC-32 step over one nibble, LSB first.
// Shared with the receive path for FCS checking.
module crc32_nibble
   import mii_pkg::*;
(
   input  logic [31:0] i_crc,
   input  logic [3:0]  i_nib,
   output logic [31:0] o_crc
);

   logic [31:0] w_c;

   // Four single-bit shift/XOR steps of the reflected polynomial
   always_comb begin
      w_c = i_crc ^ {28'd0, i_nib};
      for (int unsigned i = 0; i < 4; i++) begin
         w_c = w_c[0] ? ((w_c >> 1) ^ CRC_POLY) : (w_c >> 1);
      end
      o_crc = w_c;
   end

endmodule

// File: rtl/mii_tx_framer.sv
// MII TX framer: preamble/SFD, payload, zero pad to minimum length, FCS, IFG.
// All MII outputs are registers loaded with the value for the next cycle.
module mii_tx_framer
   import mii_pkg::*;
#(
   parameter int unsigned MIN_FRAME = 60,
   parameter int unsigned IFG_NIB   = 24
)
(
   input  logic           clk,
   input  logic           rst_n,
   mii_tx_framer_if.slave s_if,
   output logic           mii_tx_en,
   output logic [3:0]     mii_txd,
   output logic           busy,
   output logic           underrun
);

   localparam logic [5:0] LP_MIN      = 6'(MIN_FRAME);
   localparam logic [4:0] LP_IFG_LAST = 5'(IFG_NIB - 1);

   tx_state_e   r_state, w_state_n;
   logic [4:0]  r_cnt, w_cnt_n;
   logic        r_hi, w_hi_n;
   logic [3:0]  r_nib, w_nib_n;
   logic        r_last, w_last_n;
   logic [5:0]  r_bcnt, w_bcnt_n, w_bcnt_inc;
   logic [31:0] r_crc, w_crc_upd, w_fcs;
   logic [3:0]  w_fcs_nib;
   logic        w_crc_clr, w_crc_en;
   logic        r_txen, w_txen_n;
   logic [3:0]  r_txd, w_txd_n;
   logic        r_underrun, w_underrun_n;
   logic        w_ready, w_accept, w_abort;

   crc32_nibble u_crc (
      .i_crc (r_crc),
      .i_nib (w_txd_n),
      .o_crc (w_crc_upd)
   );

   assign w_bcnt_inc = (r_bcnt >= LP_MIN) ? LP_MIN : r_bcnt + 6'd1;
   assign w_fcs      = ~r_crc;
   assign w_fcs_nib  = w_fcs[{r_cnt[2:0] + 3'd1, 2'b00} +: 4];

   // Byte is taken in the SFD cycle and in each high-nibble cycle of a non-final byte
   assign w_ready  = ((r_state == ST_PREAMBLE) && (r_cnt == 5'd15)) ||
                     ((r_state == ST_DATA) && r_hi && !r_last);
   assign w_accept = w_ready && s_if.s_valid;
   assign w_abort  = w_ready && !s_if.s_valid;

   assign s_if.s_ready = w_ready;
   assign mii_tx_en    = r_txen;
   assign mii_txd      = r_txd;
   assign underrun     = r_underrun;
   assign busy         = (r_state != ST_IDLE);

   // Next-state and next-output decode; abort and accept take priority over per-state flow
   always_comb begin
      w_state_n    = r_state;
      w_cnt_n      = r_cnt;
      w_hi_n       = r_hi;
      w_nib_n      = r_nib;
      w_last_n     = r_last;
      w_bcnt_n     = r_bcnt;
      w_txen_n     = r_txen;
      w_txd_n      = r_txd;
      w_underrun_n = 1'b0;
      w_crc_clr    = 1'b0;
      w_crc_en     = 1'b0;
      if (w_abort) begin
         w_state_n    = ST_IFG;
         w_cnt_n      = '0;
         w_txen_n     = 1'b0;
         w_txd_n      = '0;
         w_underrun_n = 1'b1;
      end else if (w_accept) begin
         w_state_n = ST_DATA;
         w_hi_n    = 1'b0;
         w_nib_n   = s_if.s_data[7:4];
         w_last_n  = s_if.s_last;
         w_txd_n   = s_if.s_data[3:0];
         w_crc_en  = 1'b1;
         if (r_state == ST_DATA) begin
            w_bcnt_n = w_bcnt_inc;
         end
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (s_if.s_valid) begin
                  w_state_n = ST_PREAMBLE;
                  w_cnt_n   = '0;
                  w_txen_n  = 1'b1;
                  w_txd_n   = PREAMBLE_NIB;
                  w_crc_clr = 1'b1;
                  w_bcnt_n  = '0;
               end
            end
            ST_PREAMBLE: begin
               w_cnt_n = r_cnt + 5'd1;
               w_txd_n = (r_cnt == 5'd14) ? SFD_NIB : PREAMBLE_NIB;
            end
            ST_DATA, ST_PAD: begin
               if (!r_hi) begin
                  w_hi_n   = 1'b1;
                  w_txd_n  = (r_state == ST_DATA) ? r_nib : 4'h0;
                  w_crc_en = 1'b1;
               end else begin
                  // High nibble of the final data byte or of a pad byte
                  w_bcnt_n = w_bcnt_inc;
                  if (w_bcnt_inc < LP_MIN) begin
                     w_state_n = ST_PAD;
                     w_hi_n    = 1'b0;
                     w_txd_n   = 4'h0;
                     w_crc_en  = 1'b1;
                  end else begin
                     w_state_n = ST_FCS;
                     w_cnt_n   = '0;
                     w_txd_n   = w_fcs[3:0];
                  end
               end
            end
            ST_FCS: begin
               if (r_cnt == 5'd7) begin
                  w_state_n = ST_IFG;
                  w_cnt_n   = '0;
                  w_txen_n  = 1'b0;
                  w_txd_n   = '0;
               end else begin
                  w_cnt_n = r_cnt + 5'd1;
                  w_txd_n = w_fcs_nib;
               end
            end
            ST_IFG: begin
               if (r_cnt == LP_IFG_LAST) begin
                  w_state_n = ST_IDLE;
               end else begin
                  w_cnt_n = r_cnt + 5'd1;
               end
            end
            default: w_state_n = ST_IDLE;
         endcase
      end
   end

   // State, counters and registered MII outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_hi       <= 1'b0;
         r_nib      <= '0;
         r_last     <= 1'b0;
         r_bcnt     <= '0;
         r_txen     <= 1'b0;
         r_txd      <= '0;
         r_underrun <= 1'b0;
      end else begin
         r_state    <= w_state_n;
         r_cnt      <= w_cnt_n;
         r_hi       <= w_hi_n;
         r_nib      <= w_nib_n;
         r_last     <= w_last_n;
         r_bcnt     <= w_bcnt_n;
         r_txen     <= w_txen_n;
         r_txd      <= w_txd_n;
         r_underrun <= w_underrun_n;
      end
   end

   // Running CRC over every data/pad nibble as it is loaded onto TXD
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_crc <= CRC_INIT;
      end else if (w_crc_clr) begin
         r_crc <= CRC_INIT;
      end else if (w_crc_en) begin
         r_crc <= w_crc_upd;
      end
   end

endmodule

// File: tb/tb_mii_tx_framer.sv
// Scoreboard bench for mii_tx_framer: expected nibbles are queued with the stimulus
// and popped against what appears on TXD while TX_EN is high.
module tb_mii_tx_framer;

   logic       clk;
   logic       rst_n;
   logic       tx_en;
   logic [3:0] txd;
   logic       busy;
   logic       underrun;

   mii_tx_framer_if s_if ();

   mii_tx_framer #(.MIN_FRAME(60), .IFG_NIB(24)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_if      (s_if),
      .mii_tx_en (tx_en),
      .mii_txd   (txd),
      .busy      (busy),
      .underrun  (underrun)
   );

   logic [8:0] drv_q[$];
   logic [3:0] exp_q[$];
   logic [3:0] obs_q[$];
   int         checks;
   int         failures;

   initial begin
      clk = 1'b0;
      forever #20 clk = ~clk;
   end

   // Source: presents the head of drv_q, pops it after each completed handshake
   initial begin
      logic hs;
      s_if.s_valid = 1'b0;
      s_if.s_data  = '0;
      s_if.s_last  = 1'b0;
      forever begin
         @(negedge clk);
         hs = s_if.s_valid && s_if.s_ready && rst_n;
         @(posedge clk);
         #1;
         if (hs && drv_q.size() > 0) void'(drv_q.pop_front());
         if (drv_q.size() > 0) begin
            s_if.s_valid = 1'b1;
            {s_if.s_last, s_if.s_data} = drv_q[0];
         end else begin
            s_if.s_valid = 1'b0;
            s_if.s_last  = 1'b0;
         end
      end
   end

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'd0, b};
      for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] n);
      logic [31:0] r;
      r = c ^ {28'd0, n};
      for (int k = 0; k < 4; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   // Queue bytes for the source and the matching wire nibbles for the scoreboard
   task automatic queue_frame(input logic [7:0] pl[$], input bit aborted);
      logic [31:0] c;
      logic [31:0] fcs;
      int          n;
      n = pl.size();
      c = 32'hFFFFFFFF;
      for (int i = 0; i < 15; i++) exp_q.push_back(4'h5);
      exp_q.push_back(4'hD);
      for (int i = 0; i < n; i++) begin
         drv_q.push_back({(!aborted && i == n - 1), pl[i]});
         exp_q.push_back(pl[i][3:0]);
         exp_q.push_back(pl[i][7:4]);
         c = crc_byte(c, pl[i]);
      end
      if (!aborted) begin
         for (int i = n; i < 60; i++) begin
            exp_q.push_back(4'h0);
            exp_q.push_back(4'h0);
            c = crc_byte(c, 8'h00);
         end
         fcs = ~c;
         for (int i = 0; i < 8; i++) exp_q.push_back(fcs[4*i +: 4]);
      end
   endtask

   task automatic watch_frame(input int budget, output int nen, output int nund, output bit tmo);
      int t;
      t = 0; nen = 0; nund = 0;
      while (!tx_en && t < budget) begin @(negedge clk); t++; end
      while (tx_en && t < budget) begin
         obs_q.push_back(txd);
         nen++;
         if (underrun) nund++;
         @(negedge clk);
         t++;
      end
      tmo = (t >= budget);
   endtask

   task automatic count_ifg(input int budget, output int nifg, output int nund);
      nifg = 0; nund = 0;
      while (busy && !tx_en && nifg < budget) begin
         if (underrun) nund++;
         nifg++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (tx_en !== 1'b0) begin failures++; $display("FAIL reset_tx_en got=%b exp=0", tx_en); end
      checks++; if (txd !== 4'h0) begin failures++; $display("FAIL reset_txd got=%h exp=0", txd); end
      checks++; if (s_if.s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready got=%b exp=0", s_if.s_ready); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_full60();
      logic [7:0]  pl[$];
      logic [3:0]  o, e;
      logic [31:0] c;
      int nen, nund, nifg, nu2, idx;
      bit tmo;
      for (int i = 0; i < 60; i++) pl.push_back(8'(i * 7 + 3));
      queue_frame(pl, 1'b0);
      watch_frame(2000, nen, nund, tmo);
      checks++; if (tmo) begin failures++; $display("FAIL full60_timeout got=1 exp=0"); end
      checks++; if (nen != 144) begin failures++; $display("FAIL full60_en_len got=%0d exp=144", nen); end
      c = 32'hFFFFFFFF; idx = 0;
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
         if (idx >= 16) c = crc_nib(c, o);
         checks++; if (o !== e) begin failures++; $display("FAIL full60_nib[%0d] got=%h exp=%h", idx, o, e); end
         idx++;
      end
      checks++; if (c !== 32'hDEBB20E3) begin failures++; $display("FAIL full60_residue got=%h exp=debb20e3", c); end
      count_ifg(100, nifg, nu2);
      checks++; if (nifg != 24) begin failures++; $display("FAIL full60_ifg got=%0d exp=24", nifg); end
      checks++; if (nund + nu2 != 0) begin failures++; $display("FAIL full60_underrun got=%0d exp=0", nund + nu2); end
      exp_q.delete();
   endtask

   task automatic test_short14();
      logic [7:0] pl[$];
      logic [3:0] o, e;
      int nen, nund, nifg, nu2, idx;
      bit tmo;
      pl = '{8'h54, 8'hff, 8'h01, 8'h21, 8'h23, 8'h24, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9a, 8'hbc, 8'h12, 8'h34};
      queue_frame(pl, 1'b0);
      watch_frame(2000, nen, nund, tmo);
      checks++; if (tmo) begin failures++; $display("FAIL short14_timeout got=1 exp=0"); end
      checks++; if (nen != 144) begin failures++; $display("FAIL short14_en_len got=%0d exp=144", nen); end
      idx = 0;
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
         checks++; if (o !== e) begin failures++; $display("FAIL short14_nib[%0d] got=%h exp=%h", idx, o, e); end
         idx++;
      end
      count_ifg(100, nifg, nu2);
      checks++; if (nifg != 24) begin failures++; $display("FAIL short14_ifg got=%0d exp=24", nifg); end
      exp_q.delete();
   endtask

   task automatic test_nibble_order();
      logic [7:0] pl[$];
      logic [3:0] o, e, n16, n17;
      int nen, nund, nifg, nu2, idx;
      bit tmo;
      pl = '{8'h5A};
      queue_frame(pl, 1'b0);
      watch_frame(2000, nen, nund, tmo);
      n16 = (obs_q.size() > 17) ? obs_q[16] : 4'hx;
      n17 = (obs_q.size() > 17) ? obs_q[17] : 4'hx;
      checks++; if (n16 !== 4'hA) begin failures++; $display("FAIL order_low got=%h exp=a", n16); end
      checks++; if (n17 !== 4'h5) begin failures++; $display("FAIL order_high got=%h exp=5", n17); end
      checks++; if (nen != 144) begin failures++; $display("FAIL order_en_len got=%0d exp=144", nen); end
      idx = 0;
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
         checks++; if (o !== e) begin failures++; $display("FAIL order_nib[%0d] got=%h exp=%h", idx, o, e); end
         idx++;
      end
      count_ifg(100, nifg, nu2);
      exp_q.delete();
   endtask

   task automatic test_underrun();
      logic [7:0] pl[$];
      logic [3:0] o, e;
      logic       u_fall;
      int nen, nund, nifg, nu2, idx;
      bit tmo;
      for (int i = 0; i < 20; i++) pl.push_back(8'($urandom_range(0, 255)));
      queue_frame(pl, 1'b1);
      watch_frame(2000, nen, nund, tmo);
      u_fall = underrun;
      checks++; if (tmo) begin failures++; $display("FAIL underrun_timeout got=1 exp=0"); end
      checks++; if (nen != 56) begin failures++; $display("FAIL underrun_en_len got=%0d exp=56", nen); end
      checks++; if (u_fall !== 1'b1) begin failures++; $display("FAIL underrun_at_fall got=%b exp=1", u_fall); end
      idx = 0;
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
         checks++; if (o !== e) begin failures++; $display("FAIL underrun_nib[%0d] got=%h exp=%h", idx, o, e); end
         idx++;
      end
      count_ifg(100, nifg, nu2);
      checks++; if (nifg != 24) begin failures++; $display("FAIL underrun_ifg got=%0d exp=24", nifg); end
      checks++; if (nund + nu2 != 1) begin failures++; $display("FAIL underrun_pulses got=%0d exp=1", nund + nu2); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL underrun_idle got=%b exp=0", busy); end
      exp_q.delete();
   endtask

   task automatic test_back_to_back();
      logic [7:0] pa[$];
      logic [7:0] pb[$];
      logic [3:0] o, e, first;
      int nen, nund, nifg, nu2, gap, idx;
      bit tmo;
      for (int i = 0; i < 20; i++) pa.push_back(8'($urandom_range(0, 255)));
      for (int i = 0; i < 20; i++) pb.push_back(8'($urandom_range(0, 255)));
      queue_frame(pa, 1'b0);
      queue_frame(pb, 1'b0);
      watch_frame(2000, nen, nund, tmo);
      checks++; if (nen != 144) begin failures++; $display("FAIL b2b_en_len_a got=%0d exp=144", nen); end
      gap = 0;
      while (!tx_en && gap < 200) begin gap++; @(negedge clk); end
      checks++; if (gap != 25) begin failures++; $display("FAIL b2b_gap got=%0d exp=25", gap); end
      watch_frame(2000, nen, nund, tmo);
      checks++; if (nen != 144) begin failures++; $display("FAIL b2b_en_len_b got=%0d exp=144", nen); end
      first = (obs_q.size() > 144) ? obs_q[144] : 4'hx;
      checks++; if (first !== 4'h5) begin failures++; $display("FAIL b2b_second_preamble got=%h exp=5", first); end
      idx = 0;
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
         checks++; if (o !== e) begin failures++; $display("FAIL b2b_nib[%0d] got=%h exp=%h", idx, o, e); end
         idx++;
      end
      count_ifg(100, nifg, nu2);
      exp_q.delete();
   endtask

   task automatic test_reset_mid();
      logic [7:0] pa[$];
      logic [7:0] pb[$];
      logic [3:0] o, e;
      int nen, nund, nifg, nu2, t, idx;
      bit tmo;
      for (int i = 0; i < 60; i++) pa.push_back(8'(255 - i));
      queue_frame(pa, 1'b0);
      t = 0;
      while (!tx_en && t < 500) begin @(negedge clk); t++; end
      repeat (50) @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      checks++; if (tx_en !== 1'b0) begin failures++; $display("FAIL rstmid_tx_en got=%b exp=0", tx_en); end
      checks++; if (txd !== 4'h0) begin failures++; $display("FAIL rstmid_txd got=%h exp=0", txd); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
      drv_q.delete();
      exp_q.delete();
      obs_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      pb = '{8'hde, 8'had, 8'hbe, 8'hef, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h08, 8'h00, 8'h45, 8'h00};
      queue_frame(pb, 1'b0);
      watch_frame(2000, nen, nund, tmo);
      checks++; if (nen != 144) begin failures++; $display("FAIL rstmid_en_len got=%0d exp=144", nen); end
      idx = 0;
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
         checks++; if (o !== e) begin failures++; $display("FAIL rstmid_nib[%0d] got=%h exp=%h", idx, o, e); end
         idx++;
      end
      count_ifg(100, nifg, nu2);
      checks++; if (nifg != 24) begin failures++; $display("FAIL rstmid_ifg got=%0d exp=24", nifg); end
      exp_q.delete();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      test_reset();
      test_full60();
      test_short14();
      test_nibble_order();
      test_underrun();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
